// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt bank sequencer.
package irq_pkg;

  typedef enum logic [2:0] {
    RUN_USER,
    SAVE,
    SWITCH,
    RUN_SYS,
    RESTORE
  } state_e;

  localparam int CR_IE        = 0;
  localparam int CR_MODE      = 1;
  localparam int CR_CAUSE_LSB = 4;
  localparam int CR_CAUSE_MSB = 6;

  localparam logic [15:0] SR1_VALID = 16'h0001;
  localparam logic [15:0] SCR_BASE  = 16'h0002;

  function automatic logic [15:0] scr_value(
    input logic [2:0] c
  );
    logic [15:0] v;
    v = SCR_BASE;
    v[CR_CAUSE_MSB:CR_CAUSE_LSB] = c;
    return v;
  endfunction

endpackage

// File: rtl/irq_bank_ctrl_prio.sv
// Lowest-index-wins priority encoder over the
// level-sensitive request lines.
module irq_prio #(
  parameter int NIRQ = 4,
  parameter int CW   = 2
) (
  input  logic [NIRQ-1:0] req_i,
  output logic            valid_o,
  output logic [CW-1:0]   idx_o
);

  always_comb begin
    idx_o = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = CW'(i);
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/irq_bank_ctrl.sv
// Interrupt entry/exit sequencer for the banked regfile.
// Define IRQ_CAUSE_CR_EN to write the cause into sCR on entry.
module irq_bank_ctrl
  import irq_pkg::*;
#(
  parameter int NIRQ = 4,
  parameter int CW   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq,
  input  logic [15:0]     cr_rd,
  input  logic [15:0]     pc,
  input  logic            boundary,
  input  logic            reti,
  output logic            bank,
  output logic [15:0]     sr1_wr,
  output logic [15:0]     cr_wr,
  output logic            stall,
  output logic [NIRQ-1:0] irq_ack,
  output logic [CW-1:0]   cause
);

  state_e          state_q;
  logic            pvalid;
  logic [CW-1:0]   pidx;
  logic            take;
  logic            unused_bits;

  irq_prio #(
    .NIRQ (NIRQ),
    .CW   (CW)
  ) u_prio (
    .req_i   (irq),
    .valid_o (pvalid),
    .idx_o   (pidx)
  );

  assign take = boundary && cr_rd[CR_IE] && pvalid;
  assign unused_bits = ^{cr_rd[15:1], pc[0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN_USER;
      bank    <= 1'b0;
      stall   <= 1'b0;
      sr1_wr  <= '0;
      irq_ack <= '0;
      cause   <= '0;
    end else begin
      sr1_wr  <= '0;
      irq_ack <= '0;
      unique case (state_q)
        RUN_USER: begin
          if (take) begin
            state_q <= SAVE;
            cause   <= pidx;
            stall   <= 1'b1;
            sr1_wr  <= {pc[15:1], 1'b0} | SR1_VALID;
            irq_ack <= NIRQ'(1) << pidx;
          end
        end
        SAVE: begin
          state_q <= SWITCH;
          bank    <= 1'b1;
        end
        SWITCH: begin
          state_q <= RUN_SYS;
          stall   <= 1'b0;
        end
        RUN_SYS: begin
          // No nesting: only reti leaves the system bank.
          if (reti) begin
            state_q <= RESTORE;
            bank    <= 1'b0;
            stall   <= 1'b1;
          end
        end
        RESTORE: begin
          state_q <= RUN_USER;
          stall   <= 1'b0;
        end
        default: begin
          state_q <= RUN_USER;
          bank    <= 1'b0;
          stall   <= 1'b0;
        end
      endcase
    end
  end

`ifdef IRQ_CAUSE_CR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cr_wr <= '0;
    end else if (state_q == SAVE) begin
      cr_wr <= scr_value(3'(cause));
    end else begin
      cr_wr <= '0;
    end
  end
`else
  assign cr_wr = '0;
`endif

endmodule

// File: tb/tb_irq_bank_ctrl.sv
// Self-checking bench: sequence model plus
// directed literal checks.
module tb_irq_bank_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq;
  logic [15:0] cr_rd;
  logic [15:0] pc;
  logic        boundary;
  logic        reti;
  logic        bank;
  logic [15:0] sr1_wr;
  logic [15:0] cr_wr;
  logic        stall;
  logic [3:0]  irq_ack;
  logic [1:0]  cause;

  int checks = 0;
  int errors = 0;

  irq_bank_ctrl #(.NIRQ(4), .CW(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .irq      (irq),
    .cr_rd    (cr_rd),
    .pc       (pc),
    .boundary (boundary),
    .reti     (reti),
    .bank     (bank),
    .sr1_wr   (sr1_wr),
    .cr_wr    (cr_wr),
    .stall    (stall),
    .irq_ack  (irq_ack),
    .cause    (cause)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        bank;
    logic        stall;
    logic [15:0] sr1;
    logic [15:0] crw;
    logic [3:0]  ack;
    logic [1:0]  cause;
  } out_t;

  out_t cur = '0;
  out_t q[$];
  bit   in_sys = 0;
  int   m_cause = 0;

  function automatic out_t mk(
    input logic b, input logic s,
    input logic [15:0] r, input logic [15:0] c,
    input logic [3:0] a, input int cs
  );
    out_t o;
    o.bank  = b;
    o.stall = s;
    o.sr1   = r;
    o.crw   = c;
    o.ack   = a;
    o.cause = 2'(cs);
    return o;
  endfunction

  function automatic logic [15:0] cr_exp(input int cs);
`ifdef IRQ_CAUSE_CR_EN
    return 16'h0002 + 16'(cs * 16);
`else
    return 16'h0000;
`endif
  endfunction

  // Model: an entry emits a fixed burst of cycles,
  // then the handler runs until reti.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      in_sys  = 0;
      m_cause = 0;
      cur     = mk(0, 0, 0, 0, 0, 0);
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else if (in_sys) begin
      if (reti) begin
        cur = mk(0, 1, 0, 0, 0, m_cause);
        q.push_back(mk(0, 0, 0, 0, 0, m_cause));
        in_sys = 0;
      end else begin
        cur = mk(1, 0, 0, 0, 0, m_cause);
      end
    end else if (boundary && cr_rd[0] && irq != 0) begin
      m_cause = 0;
      while (!irq[m_cause]) m_cause++;
      cur = mk(0, 1, pc + 16'd1, 0,
               4'(1 << m_cause), m_cause);
      q.push_back(mk(1, 1, 0, cr_exp(m_cause), 0, m_cause));
      q.push_back(mk(1, 0, 0, 0, 0, m_cause));
      in_sys = 1;
    end else begin
      cur = mk(0, 0, 0, 0, 0, m_cause);
    end
  end

  always @(negedge clk) begin
    out_t d;
    d = {bank, stall, sr1_wr, cr_wr, irq_ack, cause};
    checks++;
    if (d !== cur) begin
      errors++;
      $display("FAIL model t=%0t bank=%b/%b stall=%b/%b sr1=%h/%h cr=%h/%h ack=%b/%b cause=%0d/%0d (act/req)",
               $time, d.bank, cur.bank, d.stall, cur.stall,
               d.sr1, cur.sr1, d.crw, cur.crw, d.ack, cur.ack,
               d.cause, cur.cause);
    end
  end

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 0; irq = 4'b0110; cr_rd = 16'h0001;
    pc = 16'h0000; boundary = 1; reti = 0;
    repeat (3) begin
      step();
      chk("rst_bank", 16'(bank), 16'h0);
      chk("rst_stall", 16'(stall), 16'h0);
      chk("rst_sr1", sr1_wr, 16'h0);
      chk("rst_cr", cr_wr, 16'h0);
      chk("rst_ack", 16'(irq_ack), 16'h0);
    end
    irq = 0; reset = 1;
    step(); step();

    pc = 16'h0120; irq = 4'b0100;
    step();
    chk("save_sr1", sr1_wr, 16'h0121);
    chk("save_ack", 16'(irq_ack), 16'h0004);
    chk("save_stall", 16'(stall), 16'h1);
    chk("save_bank", 16'(bank), 16'h0);
    irq = 0;
    step();
    chk("sw_bank", 16'(bank), 16'h1);
    chk("sw_stall", 16'(stall), 16'h1);
    chk("sw_ack", 16'(irq_ack), 16'h0);
`ifdef IRQ_CAUSE_CR_EN
    chk("sw_cr", cr_wr, 16'h0022);
`else
    chk("sw_cr", cr_wr, 16'h0000);
`endif
    step();
    chk("sys_stall", 16'(stall), 16'h0);
    chk("sys_bank", 16'(bank), 16'h1);
    chk("sys_cause", 16'(cause), 16'h2);

    irq = 4'b1111;
    repeat (3) step();
    chk("sys_nonest", 16'(bank), 16'h1);
    reti = 1;
    step();
    reti = 0; boundary = 0;
    chk("rest_bank", 16'(bank), 16'h0);
    chk("rest_stall", 16'(stall), 16'h1);
    step();
    chk("user_stall", 16'(stall), 16'h0);
    repeat (3) step();
    chk("noboundary", 16'(stall), 16'h0);
    irq = 0; reti = 1;
    step();
    reti = 0;
    chk("reti_user", 16'(bank), 16'h0);

    pc = 16'h0200; irq = 4'b1010; boundary = 1;
    step();
    chk("prio_ack", 16'(irq_ack), 16'h0002);
    chk("prio_cause", 16'(cause), 16'h1);
    chk("prio_sr1", sr1_wr, 16'h0201);
    irq = 4'b1000;
    step(); step();
    chk("prio_sys", 16'(bank), 16'h1);
    reti = 1;
    step();
    reti = 0;
    chk("prio_rest", 16'(stall), 16'h1);
    step();
    chk("prio_user", 16'(stall), 16'h0);
    step();
    chk("pend_ack", 16'(irq_ack), 16'h0008);
    chk("pend_cause", 16'(cause), 16'h3);
    irq = 0;
    step(); step();
    reti = 1;
    step();
    reti = 0;
    step();

    cr_rd = 16'h0000; irq = 4'b1111;
    repeat (20) begin
      step();
      chk("ie_off_stall", 16'(stall), 16'h0);
      chk("ie_off_ack", 16'(irq_ack), 16'h0);
    end

    cr_rd = 16'h0001; irq = 4'b0001;
    step();
    irq = 0;
    step();
    chk("pre_rst_bank", 16'(bank), 16'h1);
    #1 reset = 0;
    #1;
    chk("async_bank", 16'(bank), 16'h0);
    chk("async_stall", 16'(stall), 16'h0);
    chk("async_cause", 16'(cause), 16'h0);
    step();
    reset = 1;
    step();
    chk("post_rst", 16'(bank), 16'h0);
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
